sram_ctl: RTL and testbench

Registered asynchronous-SRAM access stage between the `mera400f` core memory port and the board SRAM pins. It accepts a level read/write request with a four-phase `ok` handshake and sequences CE/OE/WE with a programmable number of wait states. It owns the tri-state data bus, so the top level only inverts the strobes to active-low pins.

---
 rtl/sram_ctl_pkg.sv | 19 +
 rtl/sram_ctl.sv | 144 ++++++++++++++
 tb/tb_sram_ctl.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_ctl_pkg.sv
// sram_ctl_pkg
// Shared definitions for the SRAM access stage: the controller state
// encoding and the SRAM address/data widths.
package sram_ctl_pkg;

    localparam int RAM_AW = 18;
    localparam int RAM_DW = 16;

    // Width of the wait-state counter; holds WAIT_CYCLES-1 for 1..15.
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/sram_ctl.sv
// sram_ctl
// Registered asynchronous-SRAM access stage between the mera400f memory
// port and the board SRAM. Accepts a level rd/wr request with a four-phase
// ok handshake and sequences CE/OE/WE with WAIT_CYCLES wait states.
//
// Ports:
//   clk_sys       system clock
//   rst_          asynchronous active-low reset
//   rd, wr        level requests, held until ok (both high = write)
//   addr          word address, latched on acceptance
//   din  [0:15]   write data, bit 0 is the MSB
//   dout [0:15]   read data, valid while ok after a read
//   ok            access complete, held while the request is held
//   ram_ce/oe/we  active-high strobes (inverted at the top level)
//   ram_a         SRAM address
//   ram_d [15:0]  SRAM data bus, driven only during writes
//
// WAIT_CYCLES: number of strobe-active wait cycles, legal range 1..15.
module sram_ctl
    import sram_ctl_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk_sys,
    input  logic              rst_,
    input  logic              rd,
    input  logic              wr,
    input  logic [RAM_AW-1:0] addr,
    input  logic [0:RAM_DW-1] din,
    output logic [0:RAM_DW-1] dout,
    output logic              ok,
    output logic              ram_ce,
    output logic              ram_oe,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_a,
    inout  wire  [RAM_DW-1:0] ram_d
);

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               op_wr;
    logic [RAM_DW-1:0]  wdata;
    logic               drive;

    logic               req;
    logic               accept;
    logic               capture;
    logic               ce_nxt;
    logic               oe_nxt;
    logic               we_nxt;
    logic               drive_nxt;
    logic               ok_nxt;

    // Every pin is a register fed from the current state, so the pins show
    // each phase one clock after the state register enters it. That lag
    // gives the address/data a full setup cycle before WE and a hold cycle
    // after it.
    always_comb begin
        req        = rd | wr;
        next_state = state;
        cnt_nxt    = cnt;
        accept     = 1'b0;

        case (state)
            IDLE: begin
                if (req) begin
                    next_state = ADDR;
                    accept     = 1'b1;
                end
            end
            ADDR: begin
                next_state = WAIT;
                cnt_nxt    = CNT_W'(WAIT_CYCLES - 1);
            end
            WAIT: begin
                if (cnt == '0) begin
                    next_state = DONE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            DONE: begin
                if (!req) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase

        ce_nxt    = (state == ADDR) || (state == WAIT);
        oe_nxt    = ce_nxt && !op_wr;
        we_nxt    = (state == WAIT) && op_wr;
        // Write data stays on the bus through DONE as hold time.
        drive_nxt = op_wr && (state != IDLE);
        ok_nxt    = (state == DONE) && req;
        // Read data is sampled on the edge where OE drops, i.e. at the end
        // of the full OE window; OE is only ever high for reads.
        capture   = (state == DONE) && ram_oe;
    end

    always_ff @(posedge clk_sys or negedge rst_) begin
        if (!rst_) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk_sys or negedge rst_) begin
        if (!rst_) begin
            cnt    <= '0;
            op_wr  <= 1'b0;
            wdata  <= '0;
            ram_a  <= '0;
            dout   <= '0;
            ok     <= 1'b0;
            ram_ce <= 1'b0;
            ram_oe <= 1'b0;
            ram_we <= 1'b0;
            drive  <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            if (accept) begin
                op_wr <= wr;
                ram_a <= addr;
                // Plain assignment maps din[0] (MSB) onto wdata[15].
                wdata <= din;
            end
            if (capture) begin
                dout <= ram_d;
            end
            ok     <= ok_nxt;
            ram_ce <= ce_nxt;
            ram_oe <= oe_nxt;
            ram_we <= we_nxt;
            drive  <= drive_nxt;
        end
    end

    assign ram_d = drive ? wdata : {RAM_DW{1'bz}};

endmodule

// File: tb/tb_sram_ctl.sv
// tb_sram_ctl
// Bench for sram_ctl: an SRAM behavioural model on the bus, a transaction
// model that predicts every pin each cycle for the WAIT_CYCLES=2 instance,
// and directed scenarios with literal expectations. A second instance with
// WAIT_CYCLES=1 covers back-to-back accesses at the shortest setting.
module tb_sram_ctl;

    localparam int W_A = 2;
    localparam int W_B = 1;

    logic        clk_sys = 1'b0;
    logic        rst_;
    logic        rd, wr, rd2, wr2;
    logic [17:0] addr;
    logic [0:15] din;

    logic [0:15] dout, dout2;
    logic        ok, ok2;
    logic        ram_ce, ram_oe, ram_we;
    logic        ram_ce2, ram_oe2, ram_we2;
    logic [17:0] ram_a, ram_a2;
    wire  [15:0] ram_d, ram_d2;

    logic [15:0] mem  [0:262143];
    logic [15:0] mem2 [0:15];

    int checks = 0;
    int errors = 0;

    always #5 clk_sys = ~clk_sys;

    sram_ctl #(.WAIT_CYCLES(W_A)) dut_a (
        .clk_sys(clk_sys), .rst_(rst_), .rd(rd), .wr(wr), .addr(addr), .din(din),
        .dout(dout), .ok(ok), .ram_ce(ram_ce), .ram_oe(ram_oe), .ram_we(ram_we),
        .ram_a(ram_a), .ram_d(ram_d)
    );

    sram_ctl #(.WAIT_CYCLES(W_B)) dut_b (
        .clk_sys(clk_sys), .rst_(rst_), .rd(rd2), .wr(wr2), .addr(addr), .din(din),
        .dout(dout2), .ok(ok2), .ram_ce(ram_ce2), .ram_oe(ram_oe2), .ram_we(ram_we2),
        .ram_a(ram_a2), .ram_d(ram_d2)
    );

    // SRAM models: read drives the bus while CE&OE, write commits as WE falls
    // (a WE drop caused by reset does not commit).
    assign ram_d  = (ram_ce && ram_oe)   ? mem[ram_a]        : 16'bz;
    assign ram_d2 = (ram_ce2 && ram_oe2) ? mem2[ram_a2[3:0]] : 16'bz;

    always @(negedge ram_we)  if (rst_) mem[ram_a] <= ram_d;
    always @(negedge ram_we2) if (rst_) mem2[ram_a2[3:0]] <= ram_d2;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit sel, input logic r, input logic w,
                                 input logic [17:0] a, input logic [15:0] d);
        if (sel) begin
            rd2 = r; wr2 = w;
        end else begin
            rd = r; wr = w;
        end
        addr = a;
        din  = d;
    endtask

    // Transaction model for dut_a
    logic [15:0] ref_mem [int];
    int          m_edge   = 0;
    bit          m_active = 0;
    int          m_start  = 0;
    int          m_drop   = -1;
    bit          m_wr     = 0;
    logic [17:0] m_addr   = '0;
    logic [15:0] m_data   = '0;
    logic [15:0] m_dout   = '0;

    function automatic logic [15:0] ref_get(input logic [17:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return 16'h0000;
    endfunction

    always @(posedge clk_sys) begin
        logic        req_s;
        logic        wr_s;
        logic [17:0] a_s;
        logic [15:0] d_s;
        int          rel;
        logic        e_ce, e_oe, e_we, e_drive, e_ok;

        req_s = rd | wr;
        wr_s  = wr;
        a_s   = addr;
        d_s   = din;
        m_edge++;
        if (!rst_) begin
            m_active = 0;
            m_drop   = -1;
            m_dout   = '0;
        end else begin
            if (m_active && m_drop >= 0 && m_edge > m_drop) m_active = 0;
            if (!m_active) begin
                if (req_s) begin
                    m_active = 1;
                    m_start  = m_edge;
                    m_wr     = wr_s;
                    m_addr   = a_s;
                    m_data   = d_s;
                    m_drop   = -1;
                end
            end else begin
                rel = m_edge - m_start;
                if (rel == W_A + 2) begin
                    if (m_wr) ref_mem[int'(m_addr)] = m_data;
                    else      m_dout = ref_get(m_addr);
                end
                if (rel >= W_A + 2 && m_drop < 0 && !req_s) m_drop = m_edge;
            end
        end

        #1;
        rel     = m_edge - m_start;
        e_ce    = m_active && rel >= 1 && rel <= W_A + 1;
        e_oe    = e_ce && !m_wr;
        e_we    = m_active && m_wr && rel >= 2 && rel <= W_A + 1;
        e_drive = m_active && m_wr && rel >= 1;
        e_ok    = m_active && rel >= W_A + 2 && m_drop < 0;
        checkOutput("model ram_ce", 32'(ram_ce), 32'(e_ce));
        checkOutput("model ram_oe", 32'(ram_oe), 32'(e_oe));
        checkOutput("model ram_we", 32'(ram_we), 32'(e_we));
        checkOutput("model ok", 32'(ok), 32'(e_ok));
        checkOutput("model bus_drive", 32'(dut_a.drive), 32'(e_drive));
        checkOutput("model dout", 32'(dout), 32'(m_dout));
        if (e_ce)    checkOutput("model ram_a", 32'(ram_a), 32'(m_addr));
        if (e_drive) checkOutput("model ram_d", 32'(ram_d), 32'(m_data));
    end

    // Results of the last run_access
    int          res_ok_edge, res_oe_cnt, res_we_cnt, res_ce_rise, res_ok_lost;
    logic [15:0] res_bus, res_rdata;
    logic        res_ok_drop;

    task automatic run_access(input bit sel, input logic r, input logic w,
                              input logic [17:0] a, input logic [15:0] d, input int hold);
        logic prev_ce;
        logic ok_s, ce_s;
        prev_ce     = 1'b0;
        res_ok_edge = -1;
        res_oe_cnt  = 0;
        res_we_cnt  = 0;
        res_ce_rise = 0;
        res_ok_lost = 0;
        res_bus     = '0;
        res_rdata   = '0;
        @(negedge clk_sys);
        applyStimulus(sel, r, w, a, d);
        @(posedge clk_sys);
        // Changes after acceptance must be ignored.
        @(negedge clk_sys);
        applyStimulus(sel, r, w, ~a, ~d);
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk_sys); #1;
            ce_s = sel ? ram_ce2 : ram_ce;
            ok_s = sel ? ok2 : ok;
            if (sel ? ram_oe2 : ram_oe) res_oe_cnt++;
            if (sel ? ram_we2 : ram_we) res_we_cnt++;
            if (ce_s && !prev_ce) res_ce_rise++;
            prev_ce = ce_s;
            if (ok_s) begin
                res_ok_edge = k;
                res_bus     = sel ? ram_d2 : ram_d;
                res_rdata   = sel ? dout2 : dout;
                break;
            end
        end
        for (int k = 0; k < hold; k++) begin
            @(posedge clk_sys); #1;
            ce_s = sel ? ram_ce2 : ram_ce;
            if (!(sel ? ok2 : ok)) res_ok_lost++;
            if (ce_s && !prev_ce) res_ce_rise++;
            prev_ce = ce_s;
        end
        @(negedge clk_sys);
        applyStimulus(sel, 1'b0, 1'b0, ~a, ~d);
        @(posedge clk_sys); #1;
        res_ok_drop = sel ? ok2 : ok;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_ = 1'b0;
        rd = 0; wr = 0; rd2 = 0; wr2 = 0;
        addr = '0; din = '0;
        mem[18'h12345] = 16'hBEEF; ref_mem[32'h12345] = 16'hBEEF;
        mem[18'h3FFFF] = 16'h0000; ref_mem[32'h3FFFF] = 16'h0000;
        mem[18'h00100] = 16'h1111; ref_mem[32'h00100] = 16'h1111;
        mem[18'h00200] = 16'h0000; ref_mem[32'h00200] = 16'h0000;
        for (int i = 0; i < 16; i++) mem2[i] = 16'h0000;
        mem2[5] = 16'hA5C3;
        mem2[6] = 16'h0F0F;

        // Reset state
        repeat (2) @(negedge clk_sys);
        #1;
        checkOutput("reset ok", 32'(ok), 0);
        checkOutput("reset strobes", {29'd0, ram_ce, ram_oe, ram_we}, 0);
        checkOutput("reset ram_a", 32'(ram_a), 0);
        checkOutput("reset dout", 32'(dout), 0);
        checkOutput("reset bus_drive", 32'(dut_a.drive), 0);
        @(negedge clk_sys);
        rst_ = 1'b1;

        $display("[TB] read");
        run_access(0, 1, 0, 18'h12345, 16'h0000, 0);
        checkOutput("read ok_edge", 32'(res_ok_edge), 4);
        checkOutput("read dout", 32'(res_rdata), 32'hBEEF);
        checkOutput("read oe_cycles", 32'(res_oe_cnt), 3);
        checkOutput("read we_cycles", 32'(res_we_cnt), 0);
        checkOutput("read ok_after_drop", 32'(res_ok_drop), 0);

        $display("[TB] write then read back");
        run_access(0, 0, 1, 18'h3FFFF, 16'h8001, 0);
        checkOutput("write ok_edge", 32'(res_ok_edge), 4);
        checkOutput("write we_cycles", 32'(res_we_cnt), 2);
        checkOutput("write oe_cycles", 32'(res_oe_cnt), 0);
        checkOutput("write bus_in_done", 32'(res_bus), 32'h8001);
        checkOutput("write mem", 32'(mem[18'h3FFFF]), 32'h8001);
        run_access(0, 1, 0, 18'h3FFFF, 16'h0000, 0);
        checkOutput("readback dout", 32'(res_rdata), 32'h8001);

        $display("[TB] held request");
        run_access(0, 1, 0, 18'h12345, 16'h0000, 20);
        checkOutput("held ok_lost", 32'(res_ok_lost), 0);
        checkOutput("held ce_assertions", 32'(res_ce_rise), 1);
        checkOutput("held ok_after_drop", 32'(res_ok_drop), 0);

        $display("[TB] reset mid-access");
        @(negedge clk_sys);
        applyStimulus(0, 1'b0, 1'b1, 18'h00100, 16'h2222);
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        checkOutput("rst we_before", 32'(ram_we), 1);
        rst_ = 1'b0;
        #1;
        checkOutput("rst strobes", {29'd0, ram_ce, ram_oe, ram_we}, 0);
        checkOutput("rst bus_drive", 32'(dut_a.drive), 0);
        checkOutput("rst ok", 32'(ok), 0);
        applyStimulus(0, 1'b0, 1'b0, 18'h00100, 16'h2222);
        repeat (2) @(posedge clk_sys);
        @(negedge clk_sys);
        checkOutput("rst mem_unchanged", 32'(mem[18'h00100]), 32'h1111);
        rst_ = 1'b1;
        @(posedge clk_sys); #1;
        checkOutput("rst ok_after_release", 32'(ok), 0);
        run_access(0, 1, 0, 18'h00100, 16'h0000, 0);
        checkOutput("rst read ok_edge", 32'(res_ok_edge), 4);
        checkOutput("rst read dout", 32'(res_rdata), 32'h1111);

        $display("[TB] rd+wr together");
        run_access(0, 1, 1, 18'h00200, 16'h5A5A, 0);
        checkOutput("rdwr we_cycles", 32'(res_we_cnt), 2);
        checkOutput("rdwr oe_cycles", 32'(res_oe_cnt), 0);
        checkOutput("rdwr mem", 32'(mem[18'h00200]), 32'h5A5A);

        $display("[TB] back-to-back");
        run_access(0, 1, 0, 18'h12345, 16'h0000, 0);
        checkOutput("b2b first dout", 32'(res_rdata), 32'hBEEF);
        run_access(0, 1, 0, 18'h3FFFF, 16'h0000, 0);
        checkOutput("b2b second ok_edge", 32'(res_ok_edge), 4);
        checkOutput("b2b second dout", 32'(res_rdata), 32'h8001);

        run_access(1, 1, 0, 18'h00005, 16'h0000, 0);
        checkOutput("w1 ok_edge", 32'(res_ok_edge), 3);
        checkOutput("w1 oe_cycles", 32'(res_oe_cnt), 2);
        checkOutput("w1 dout", 32'(res_rdata), 32'hA5C3);
        run_access(1, 1, 0, 18'h00006, 16'h0000, 0);
        checkOutput("w1 b2b ok_edge", 32'(res_ok_edge), 3);
        checkOutput("w1 b2b dout", 32'(res_rdata), 32'h0F0F);
        run_access(1, 0, 1, 18'h00007, 16'h1234, 0);
        checkOutput("w1 write we_cycles", 32'(res_we_cnt), 1);
        checkOutput("w1 write mem", 32'(mem2[7]), 32'h1234);
        checkOutput("w1 ok_after_drop", 32'(res_ok_drop), 0);

        repeat (2) @(posedge clk_sys);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
